mult_div: RTL and testbench

Multicycle signed multiply/divide unit serving the MIPS datapath's MULT and DIV R-type instructions (funct 011000 / 011010). It sits directly downstream of the control unit: the control unit pulses `start` with the operation select, then waits on `done` before writing HI/LO back to the register file via MFHI/MFLO. Multiply uses radix-2 Booth iteration; divide uses restoring division on magnitudes with sign correction. Each takes 32 iteration cycles.

---
 rtl/mult_div_if.sv | 26 ++
 rtl/mult_div.sv | 225 ++++++++++++++++++++++
 tb/tb_mult_div.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Handshake and operand/result bundle between the control unit and mult_div.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    // Control unit side: issues requests, consumes results.
    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_zero
    );

    // Arithmetic unit side.
    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div.sv
// Multicycle signed MULT/DIV unit for the MIPS datapath.
// MULT: radix-2 Booth, DIV: restoring division on magnitudes with sign fix-up.
// Both run WIDTH iteration cycles followed by one FINISH cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start; operands captured on the accepting edge
// MULT_RUN | one Booth add/shift step per cycle
// DIV_RUN  | one restoring shift/subtract step per cycle
// FINISH   | apply signs, write hi/lo (or flag divide-by-zero), pulse done
module mult_div #(
    parameter int WIDTH = 32
) (
    input logic       clock,
    input logic       reset,
    mult_div_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        FINISH   = 2'd3
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

    state_t state;
    state_t state_next;

    logic [5:0]       count;
    // Booth accumulator / division remainder. The extra top bit keeps the
    // Booth partial sum exact when the multiplicand is the most negative value
    // (e.g. 0 - 0x80000000 must be +2^31, not -2^31).
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic             q_1;
    logic             op_div;
    logic             sign_a;
    logic             sign_b;
    logic             zero_flag;

    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;
    logic             div_zero_reg;

    logic             last_iter;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_acc;
    logic [WIDTH-1:0] booth_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   d_ext;
    logic             fits;
    logic [WIDTH:0]   r_new;
    logic [WIDTH:0]   div_acc;
    logic [WIDTH-1:0] div_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quot_signed;
    logic [WIDTH-1:0] rem_signed;

    assign last_iter = (count == CNT_LAST);

    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_reg;
    assign bus.div_zero = div_zero_reg;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.op) begin
                        state_next = MULT_RUN;
                    end else if (bus.b == '0) begin
                        state_next = FINISH;
                    end else begin
                        state_next = DIV_RUN;
                    end
                end
            end
            MULT_RUN: begin
                if (last_iter) begin
                    state_next = FINISH;
                end
            end
            DIV_RUN: begin
                if (last_iter) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand magnitudes used when a divide is captured.
    always_comb begin
        a_mag = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
        b_mag = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
    end

    // One Booth step: conditional add/subtract, then arithmetic right shift
    // of {acc, q_reg, q_1}.
    always_comb begin
        m_ext = {m_reg[WIDTH-1], m_reg};
        booth_sum = acc;
        case ({q_reg[0], q_1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_q   = {booth_sum[0], q_reg[WIDTH-1:1]};
    end

    // One restoring-division step. The remainder always stays below the
    // divisor, so it fits WIDTH bits; the shifted trial value needs one more.
    always_comb begin
        r_shift = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
        d_ext   = {1'b0, m_reg};
        fits    = (r_shift >= d_ext);
        r_new   = fits ? (r_shift - d_ext) : r_shift;
        div_acc = {1'b0, r_new[WIDTH-1:0]};
        div_q   = {q_reg[WIDTH-2:0], fits};
    end

    // Sign correction: quotient negative when signs differ, remainder follows
    // the dividend. Negation wraps, so 0x80000000 / -1 yields 0x80000000.
    always_comb begin
        quot_signed = (sign_a ^ sign_b) ? (~q_reg + 1'b1) : q_reg;
        rem_signed  = sign_a ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    end

    // Datapath: capture, iterate, and commit results in FINISH.
    always_ff @(posedge clock) begin
        if (reset) begin
            count        <= '0;
            acc          <= '0;
            q_reg        <= '0;
            m_reg        <= '0;
            q_1          <= 1'b0;
            op_div       <= 1'b0;
            sign_a       <= 1'b0;
            sign_b       <= 1'b0;
            zero_flag    <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count     <= '0;
                        acc       <= '0;
                        q_1       <= 1'b0;
                        op_div    <= bus.op;
                        sign_a    <= bus.a[WIDTH-1];
                        sign_b    <= bus.b[WIDTH-1];
                        zero_flag <= bus.op && (bus.b == '0);
                        if (bus.op) begin
                            q_reg <= a_mag;
                            m_reg <= b_mag;
                        end else begin
                            q_reg <= bus.b;
                            m_reg <= bus.a;
                        end
                    end
                end
                MULT_RUN: begin
                    acc   <= booth_acc;
                    q_reg <= booth_q;
                    q_1   <= q_reg[0];
                    count <= count + 6'd1;
                end
                DIV_RUN: begin
                    acc   <= div_acc;
                    q_reg <= div_q;
                    count <= count + 6'd1;
                end
                FINISH: begin
                    done_reg <= 1'b1;
                    if (zero_flag) begin
                        div_zero_reg <= 1'b1;
                    end else if (op_div) begin
                        hi_reg <= rem_signed;
                        lo_reg <= quot_signed;
                    end else begin
                        hi_reg <= acc[WIDTH-1:0];
                        lo_reg <= q_reg;
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: hand-computed MULT/DIV results, latency,
// busy/done framing, divide-by-zero, ignored start and mid-operation reset.
module tb_mult_div;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count a comparison and report it if observed differs from expected.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request at the current negedge, let E0 take it, drop start.
    task automatic launch(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h0BAD_F00D;
        bus.op    = ~o;
        chk({tag, "_busy_e0"}, 64'(bus.busy), 64'd1);
        chk({tag, "_done_low_e0"}, 64'(bus.done), 64'd0);
    endtask

    // Count edges after E0 until done, optionally poking a stray start.
    task automatic wait_done(input int poke_at, output int cycles, output bit busy_ok);
        bit seen;
        seen    = 1'b0;
        cycles  = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (n == poke_at) begin
                bus.start = 1'b1;
                bus.op    = 1'b1;
                bus.a     = 32'd100;
                bus.b     = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                seen   = 1'b1;
                cycles = n;
                if (bus.busy) busy_ok = 1'b0;
            end else if (!bus.busy) begin
                busy_ok = 1'b0;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y,
                         input int poke_at, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_lat, input logic exp_dz);
        int cycles;
        bit busy_ok;
        launch(tag, o, x, y);
        wait_done(poke_at, cycles, busy_ok);
        chk({tag, "_latency"}, 64'(cycles), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        chk({tag, "_div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
    endtask

    initial begin
        bit saw_done;
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_div_zero", 64'(bus.div_zero), 64'd0);

        // 7 * -3 = -21
        do_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0);
        // (-2^31)^2 = 2^62
        do_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 32'h0, 33, 1'b0);
        // -1 * -1 = 1
        do_op("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0, 32'h1, 33, 1'b0);
        // -7 / 2 = -3 rem -1
        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
        // 7 / -2 = -3 rem 1
        do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0, 32'h1, 32'hFFFF_FFFD, 33, 1'b0);
        // -2^31 / -1 wraps to -2^31 rem 0
        do_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h8000_0000, 33, 1'b0);
        // 0x451 / 0x20 = 0x22 rem 0x11, sets up hi/lo for the divide-by-zero case
        do_op("div_prep", 1'b1, 32'h451, 32'h20, 0, 32'h11, 32'h22, 33, 1'b0);
        // 5 / 0: one-cycle turnaround, hi/lo untouched
        do_op("div_zero", 1'b1, 32'd5, 32'd0, 0, 32'h11, 32'h22, 1, 1'b1);
        // 6 * 7 with a stray DIV start at cycle 5 that must be ignored
        do_op("mul_ignore", 1'b0, 32'd6, 32'd7, 5, 32'h0, 32'd42, 33, 1'b0);

        // Reset in cycle 10 of a MULT: everything clears, no done follows.
        launch("mul_abort", 1'b0, 32'd9, 32'd9);
        repeat (9) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_div_zero", 64'(bus.div_zero), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("abort_quiet", 64'(saw_done), 64'd0);

        // 100 / 7 = 14 rem 2
        do_op("div_100_7", 1'b1, 32'd100, 32'd7, 0, 32'd2, 32'd14, 33, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
